// File: rtl/amiga_dtack_gen.sv
// 68000 bus-cycle sequencer: ROM wait states, chip-bus XRDY handshake, registered _DTACK/_ROMOE.
// Define AMIGA_DTACK_BERR_EN to add a tick-counted bus-error timeout on _BERR.
module amiga_dtack_gen #(
    parameter int ROM_WAIT = 2,
    parameter int TO_WIDTH = 8,
    parameter int TIMEOUT  = 200
) (
    input  logic CLK,
    input  logic _RESET,
    input  logic _AS,
    input  logic _OVR,
    input  logic _ROME,
    input  logic _DAE,
    input  logic XRDY,
    input  logic _C1,
    input  logic _C3,
    output logic _DTACK,
    output logic _ROMOE,
    output logic _BERR
);

    if (ROM_WAIT < 0 || ROM_WAIT > 15) begin : g_bad_rom_wait
        $error("ROM_WAIT must be 0..15");
    end
    if (TIMEOUT < 1 || TIMEOUT >= (1 << TO_WIDTH)) begin : g_bad_timeout
        $error("TIMEOUT must fit in TO_WIDTH bits");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROM,
        ST_CHIP,
        ST_ACK
`ifdef AMIGA_DTACK_BERR_EN
        , ST_BERR
`endif
    } state_e;

    state_e     state_q;
    logic [3:0] wcnt_q;
    logic       dtack_q, romoe_q;
    logic       as_q, ovr_q, rome_q, dae_q, xrdy_q, c1_q, c3_q, ph_prev_q;
    logic       ph, tick, abort;

    // All decisions use one-CLK-registered copies of the asynchronous bus inputs.
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            as_q      <= 1'b1;
            ovr_q     <= 1'b1;
            rome_q    <= 1'b1;
            dae_q     <= 1'b1;
            xrdy_q    <= 1'b0;
            c1_q      <= 1'b0;
            c3_q      <= 1'b1;
            ph_prev_q <= 1'b0;
        end else begin
            as_q      <= _AS;
            ovr_q     <= _OVR;
            rome_q    <= _ROME;
            dae_q     <= _DAE;
            xrdy_q    <= XRDY;
            c1_q      <= _C1;
            c3_q      <= _C3;
            ph_prev_q <= ph;
        end
    end

    assign ph    = c1_q & ~c3_q;
    assign tick  = ph & ~ph_prev_q;
    assign abort = as_q | ~ovr_q;

`ifdef AMIGA_DTACK_BERR_EN
    logic [TO_WIDTH-1:0] to_cnt_q;
    logic [TO_WIDTH:0]   to_inc;
    logic                to_hit;
    logic                berr_q;

    assign to_inc = {1'b0, to_cnt_q} + (TO_WIDTH+1)'(1);
    assign to_hit = tick & (to_inc >= (TO_WIDTH+1)'(TIMEOUT));
    assign _BERR  = berr_q;
`else
    assign _BERR  = 1'b1;
`endif

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state_q  <= ST_IDLE;
            wcnt_q   <= 4'd0;
            dtack_q  <= 1'b1;
            romoe_q  <= 1'b1;
`ifdef AMIGA_DTACK_BERR_EN
            to_cnt_q <= '0;
            berr_q   <= 1'b1;
`endif
        end else begin
`ifdef AMIGA_DTACK_BERR_EN
            // Saturating tick count while waiting; cleared on cycle entry below.
            if ((state_q == ST_ROM || state_q == ST_CHIP) && tick && (to_cnt_q != '1))
                to_cnt_q <= to_cnt_q + TO_WIDTH'(1);
`endif
            case (state_q)
                ST_IDLE: begin
                    dtack_q <= 1'b1;
                    romoe_q <= 1'b1;
`ifdef AMIGA_DTACK_BERR_EN
                    berr_q  <= 1'b1;
`endif
                    if (!as_q && ovr_q) begin
                        if (!rome_q) begin
                            state_q <= ST_ROM;
                            wcnt_q  <= 4'(ROM_WAIT);
                            romoe_q <= 1'b0;
`ifdef AMIGA_DTACK_BERR_EN
                            to_cnt_q <= '0;
`endif
                        end else if (!dae_q) begin
                            state_q <= ST_CHIP;
`ifdef AMIGA_DTACK_BERR_EN
                            to_cnt_q <= '0;
`endif
                        end
                    end
                end
                ST_ROM: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        romoe_q <= 1'b1;
                    end else if (tick) begin
                        if (wcnt_q == 4'd0) begin
                            state_q <= ST_ACK;
                            dtack_q <= 1'b0;
                        end
`ifdef AMIGA_DTACK_BERR_EN
                        else if (to_hit) begin
                            state_q <= ST_BERR;
                            romoe_q <= 1'b1;
                            berr_q  <= 1'b0;
                        end
`endif
                        else begin
                            wcnt_q <= wcnt_q - 4'd1;
                        end
                    end
                end
                ST_CHIP: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                    end else if (tick && xrdy_q && !dae_q) begin
                        state_q <= ST_ACK;
                        dtack_q <= 1'b0;
                    end
`ifdef AMIGA_DTACK_BERR_EN
                    else if (to_hit) begin
                        state_q <= ST_BERR;
                        berr_q  <= 1'b0;
                    end
`endif
                end
                ST_ACK: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        dtack_q <= 1'b1;
                        romoe_q <= 1'b1;
                    end
                end
`ifdef AMIGA_DTACK_BERR_EN
                ST_BERR: begin
                    if (as_q) begin
                        state_q <= ST_IDLE;
                        berr_q  <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                    dtack_q <= 1'b1;
                    romoe_q <= 1'b1;
                end
            endcase
        end
    end

    assign _DTACK = dtack_q;
    assign _ROMOE = romoe_q;

endmodule

// File: tb/tb_amiga_dtack_gen.sv
// Bench for amiga_dtack_gen: directed scenarios plus random bus cycles against a cycle-level model.
module tb_amiga_dtack_gen;
    localparam int ROM_WAIT = 2;
    localparam int TO_WIDTH = 8;
    localparam int TIMEOUT  = 200;
`ifdef AMIGA_DTACK_BERR_EN
    localparam bit BERR_EN = 1'b1;
`else
    localparam bit BERR_EN = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic as_n = 1'b1, ovr_n = 1'b1, rome_n = 1'b1, dae_n = 1'b1, xrdy = 1'b0;
    logic [2:0] ph_cnt = 3'd0, ph_sh;
    logic c1_n, c3_n, dtack_n, romoe_n, berr_n;

    assign ph_sh = ph_cnt + 3'd2;
    assign c1_n  = (ph_cnt < 3'd4);
    assign c3_n  = (ph_sh < 3'd4);

    amiga_dtack_gen #(.ROM_WAIT(ROM_WAIT), .TO_WIDTH(TO_WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .CLK(clk), ._RESET(rst_n), ._AS(as_n), ._OVR(ovr_n), ._ROME(rome_n), ._DAE(dae_n),
        .XRDY(xrdy), ._C1(c1_n), ._C3(c3_n), ._DTACK(dtack_n), ._ROMOE(romoe_n), ._BERR(berr_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ph_cnt <= ph_cnt + 3'd1;

    int n_cmp = 0, n_bad = 0, pulses = 0;
    logic prev_dtack = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: bus-cycle phases with an up-counting tick total per cycle.
    localparam int M_IDLE = 0, M_ROM = 1, M_CHIP = 2, M_ACK = 3, M_BERR = 4;
    int m_mode, m_ticks;
    bit m_rom, s_as, s_ovr, s_rome, s_dae, s_xrdy, s_ph, m_php;
    bit e_dtack = 1'b1, e_romoe = 1'b1, e_berr = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        int nm, nt;
        bit nr, tk, done;
        if (!rst_n) begin
            m_mode <= M_IDLE; m_ticks <= 0; m_rom <= 1'b0;
            s_as <= 1'b1; s_ovr <= 1'b1; s_rome <= 1'b1; s_dae <= 1'b1; s_xrdy <= 1'b0;
            s_ph <= 1'b0; m_php <= 1'b0;
            e_dtack <= 1'b1; e_romoe <= 1'b1; e_berr <= 1'b1;
        end else begin
            nm = m_mode; nt = m_ticks; nr = m_rom;
            tk = s_ph && !m_php;
            if (m_mode == M_IDLE) begin
                if (!s_as && s_ovr) begin
                    if (!s_rome) begin nm = M_ROM; nr = 1'b1; nt = 0; end
                    else if (!s_dae) begin nm = M_CHIP; nr = 1'b0; nt = 0; end
                end
            end else if (m_mode == M_ROM || m_mode == M_CHIP) begin
                if (s_as || !s_ovr) nm = M_IDLE;
                else if (tk) begin
                    nt = nt + 1;
                    done = (m_mode == M_ROM) ? (nt == ROM_WAIT + 1) : (s_xrdy && !s_dae);
                    if (done) nm = M_ACK;
                    else if (BERR_EN && nt >= TIMEOUT) nm = M_BERR;
                end
            end else if (m_mode == M_ACK) begin
                if (s_as || !s_ovr) nm = M_IDLE;
            end else begin
                if (s_as) nm = M_IDLE;
            end
            m_mode <= nm; m_ticks <= nt; m_rom <= nr;
            e_dtack <= (nm != M_ACK);
            e_romoe <= !(nm == M_ROM || (nm == M_ACK && nr));
            e_berr  <= (nm != M_BERR);
            m_php <= s_ph;
            s_as <= as_n; s_ovr <= ovr_n; s_rome <= rome_n; s_dae <= dae_n; s_xrdy <= xrdy;
            s_ph <= c1_n && !c3_n;
        end
    end

    always @(negedge clk) begin
        chk("dtack", dtack_n, e_dtack);
        chk("romoe", romoe_n, e_romoe);
        chk("berr", berr_n, e_berr);
        if (prev_dtack && !dtack_n) pulses <= pulses + 1;
        prev_dtack <= dtack_n;
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ph(input logic [2:0] v);
        for (int i = 0; i < 16; i++) begin
            if (ph_cnt == v) break;
            step(1);
        end
    endtask

    task automatic idle_bus();
        as_n = 1'b1; rome_n = 1'b1; dae_n = 1'b1; ovr_n = 1'b1; xrdy = 1'b0;
    endtask

    task automatic wait_ack(input int lim, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (!dtack_n) begin seen = 1'b1; break; end
            step(1);
        end
    endtask

    initial begin
        logic seen, any;
        int p0, hold;
        step(3); rst_n = 1'b1; step(2);
        chk("rst_dtack", dtack_n, 1); chk("rst_romoe", romoe_n, 1); chk("rst_berr", berr_n, 1);

        // Reset in the middle of a chip cycle.
        as_n = 1'b0; dae_n = 1'b0; step(6);
        rst_n = 1'b0; idle_bus(); #1;
        chk("t1_rst_dtack", dtack_n, 1); chk("t1_rst_romoe", romoe_n, 1);
        step(3); rst_n = 1'b1; step(4);
        chk("t1_post_dtack", dtack_n, 1);

        // ROM read latency.
        as_n = 1'b0; rome_n = 1'b0;
        step(1); chk("t2_romoe_lat1", romoe_n, 1);
        step(1); chk("t2_romoe_lat2", romoe_n, 0);
        wait_ack(64, seen);
        chk("t2_ack_seen", seen, 1); chk("t2_romoe_in_ack", romoe_n, 0);
        step(2); as_n = 1'b1; rome_n = 1'b1;
        step(1); chk("t2_dtack_hold", dtack_n, 0);
        step(1); chk("t2_dtack_rel", dtack_n, 1); chk("t2_romoe_rel", romoe_n, 1);
        step(2);

        // Chip cycle: XRDY only pulsed between ticks, then held high.
        as_n = 1'b0; dae_n = 1'b0;
        for (int t = 0; t < 5; t++) begin
            wait_ph(3'd5); xrdy = 1'b1; step(1); xrdy = 1'b0; step(1);
        end
        chk("t3_no_early_ack", dtack_n, 1);
        xrdy = 1'b1;
        wait_ack(32, seen);
        chk("t3_ack_seen", seen, 1);
        idle_bus(); step(3);
        chk("t3_rel", dtack_n, 1);

        // Override keeps the block passive; early abort of a ROM cycle.
        p0 = pulses; any = 1'b0;
        ovr_n = 1'b0; rome_n = 1'b0; as_n = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (!romoe_n || !dtack_n) any = 1'b1;
        end
        chk("t4_ovr_quiet", any, 0);
        idle_bus(); step(2);
        wait_ph(3'd0); as_n = 1'b0; rome_n = 1'b0;
        step(6); as_n = 1'b1; rome_n = 1'b1; step(3);
        chk("t4_abort_no_ack", pulses - p0, 0); chk("t4_abort_romoe", romoe_n, 1);

        // ROM priority, then back-to-back with a one-CLK gap.
        p0 = pulses;
        as_n = 1'b0; rome_n = 1'b0; dae_n = 1'b0;
        step(2); chk("t5_rom_prio", romoe_n, 0);
        wait_ack(64, seen); chk("t5_ack1", seen, 1);
        as_n = 1'b1; step(1); as_n = 1'b0;
        step(2);
        wait_ack(64, seen); chk("t5_ack2", seen, 1);
        idle_bus(); step(3);
        chk("t5_two_pulses", pulses - p0, 2);

        // Chip cycle with XRDY stuck low.
        as_n = 1'b0; dae_n = 1'b0; xrdy = 1'b0; seen = 1'b0;
        for (int i = 0; i < 1800; i++) begin
            step(1);
            if (!berr_n) begin seen = 1'b1; break; end
        end
        chk("t6_berr_seen", seen, BERR_EN); chk("t6_dtack_hi", dtack_n, 1);
        idle_bus(); step(3);
        chk("t6_berr_rel", berr_n, 1);

        // Random bus cycles against the model.
        for (int r = 0; r < 120; r++) begin
            rome_n = ($urandom_range(0, 2) != 0);
            dae_n  = 1'($urandom_range(0, 1));
            ovr_n  = ($urandom_range(0, 7) != 0);
            as_n   = 1'b0;
            hold   = int'($urandom_range(2, 60));
            for (int i = 0; i < hold; i++) begin
                xrdy = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 40) == 0) ovr_n = 1'b0;
                step(1);
                if (!dtack_n) break;
            end
            step(int'($urandom_range(0, 3)));
            idle_bus();
            step(int'($urandom_range(1, 4)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
